// File: rtl/ysyx_22050039_mem_arb.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing one memory port between instruction fetch and load/store.
// One transaction is in flight at a time; a watchdog answers with an error if memory stalls.
module ysyx_22050039_mem_arb #(
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [XLEN-1:0]   if_addr,
    output logic              if_resp_valid,
    output logic [XLEN-1:0]   if_rdata,
    output logic              if_resp_err,

    input  logic              ls_req_valid,
    output logic              ls_req_ready,
    input  logic [XLEN-1:0]   ls_addr,
    input  logic              ls_wen,
    input  logic [XLEN-1:0]   ls_wdata,
    input  logic [XLEN/8-1:0] ls_wmask,
    output logic              ls_resp_valid,
    output logic [XLEN-1:0]   ls_rdata,
    output logic              ls_resp_err,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [XLEN-1:0]   mem_addr,
    output logic              mem_wen,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [XLEN-1:0]   mem_rdata,

    output logic              busy,
    output logic              owner
);

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state;
    logic            last_grant;
    logic [CW-1:0]   cnt;

    logic            idle;
    logic            grant_ls;
    logic            timeout_hit;
    logic            fin;
    logic            fin_err;
    logic [XLEN-1:0] fin_data;

    // Handshake semantics: a request transfers on a cycle where the requester's valid and
    // the arbiter's ready are both high; ready is only ever raised in IDLE, for the winner.
    // The memory request transfers when mem_req_valid and mem_req_ready are both high, and
    // mem_req_valid stays up with stable fields until then (or until the watchdog fires).
    assign idle         = (state == IDLE);
    assign grant_ls     = ls_req_valid & (~if_req_valid | ~last_grant);
    assign if_req_ready = rst & idle & if_req_valid & ~grant_ls;
    assign ls_req_ready = rst & idle & grant_ls;
    assign busy         = ~idle;
    assign timeout_hit  = (cnt == CNT_LAST);

    // A completing event in the watchdog cycle takes priority over the timeout.
    always_comb begin
        fin      = 1'b0;
        fin_err  = 1'b0;
        fin_data = '0;
        case (state)
            ISSUE: begin
                if (!mem_req_ready && timeout_hit) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    fin      = 1'b1;
                    fin_data = mem_wen ? '0 : mem_rdata;
                end else if (timeout_hit) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
            end
            default: begin
                fin = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            owner         <= 1'b0;
            cnt           <= '0;
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            mem_wen       <= 1'b0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
            if_resp_valid <= 1'b0;
            if_rdata      <= '0;
            if_resp_err   <= 1'b0;
            ls_resp_valid <= 1'b0;
            ls_rdata      <= '0;
            ls_resp_err   <= 1'b0;
        end else begin
            if_resp_valid <= 1'b0;
            if_resp_err   <= 1'b0;
            ls_resp_valid <= 1'b0;
            ls_resp_err   <= 1'b0;

            case (state)
                IDLE: begin
                    if (if_req_valid || ls_req_valid) begin
                        owner         <= grant_ls;
                        last_grant    <= grant_ls;
                        cnt           <= '0;
                        mem_req_valid <= 1'b1;
                        state         <= ISSUE;
                        if (grant_ls) begin
                            mem_addr  <= ls_addr;
                            mem_wen   <= ls_wen;
                            mem_wdata <= ls_wdata;
                            mem_wmask <= ls_wmask;
                        end else begin
                            mem_addr  <= if_addr;
                            mem_wen   <= 1'b0;
                            mem_wdata <= '0;
                            mem_wmask <= '0;
                        end
                    end
                end
                ISSUE: begin
                    cnt <= cnt + CW'(1);
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WAIT;
                    end else if (timeout_hit) begin
                        mem_req_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    cnt <= cnt + CW'(1);
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (fin) begin
                state <= RESP;
                if (owner) begin
                    ls_resp_valid <= 1'b1;
                    ls_rdata      <= fin_data;
                    ls_resp_err   <= fin_err;
                end else begin
                    if_resp_valid <= 1'b1;
                    if_rdata      <= fin_data;
                    if_resp_err   <= fin_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22050039_mem_arb.sv
`timescale 1ns/1ps
// Directed plus randomized bench for the memory arbiter, with a configurable memory
// responder and a round-robin/data reference model.
module tb_ysyx_22050039_mem_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid, if_req_ready, if_resp_valid, if_resp_err;
    logic [63:0] if_addr, if_rdata;
    logic        ls_req_valid, ls_req_ready, ls_wen, ls_resp_valid, ls_resp_err;
    logic [63:0] ls_addr, ls_wdata, ls_rdata;
    logic [7:0]  ls_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;
    logic        busy, owner;

    int errors = 0;
    int checks = 0;

    // reference model state: who was granted last (1 = LS) and expected response data
    bit          ref_last;
    logic [63:0] exp_q[$];

    // memory responder knobs and request log
    int          ready_delay = 0;
    int          resp_delay  = 0;
    bit          no_resp     = 0;
    bit          late_resp   = 0;
    logic [63:0] log_addr[$];
    logic [63:0] log_wdata[$];
    logic        log_wen[$];
    logic [7:0]  log_wmask[$];

    ysyx_22050039_mem_arb #(.XLEN(64), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_resp_valid(if_resp_valid), .if_rdata(if_rdata), .if_resp_err(if_resp_err),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
        .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
        .ls_resp_valid(ls_resp_valid), .ls_rdata(ls_rdata), .ls_resp_err(ls_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .busy(busy), .owner(owner)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [63:0] memf(input logic [63:0] a);
        if (a == 64'h0000_0000_8000_0000) return 64'h0000_0000_0010_0073;
        return a ^ 64'hA5A5_0F0F_1234_5678;
    endfunction

    // memory responder: accepts after ready_delay cycles, answers resp_delay cycles later
    int          rdy_cnt = 0;
    int          rsp_cnt = 0;
    bit          pending = 0;
    logic [63:0] p_addr;
    logic        p_wen;

    always @(negedge clk) begin
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
        if (!rst) begin
            pending = 0;
            rdy_cnt = 0;
            rsp_cnt = 0;
        end else if (late_resp) begin
            mem_resp_valid = 1'b1;
            mem_rdata      = 64'hBAD0_BAD0_BAD0_BAD0;
        end else if (!busy && !mem_req_valid) begin
            pending = 0;
            rdy_cnt = 0;
        end else if (mem_req_valid && !pending) begin
            if (rdy_cnt >= ready_delay) begin
                mem_req_ready = 1'b1;
                log_addr.push_back(mem_addr);
                log_wen.push_back(mem_wen);
                log_wdata.push_back(mem_wdata);
                log_wmask.push_back(mem_wmask);
                p_addr  = mem_addr;
                p_wen   = mem_wen;
                pending = 1;
                rsp_cnt = 0;
            end else begin
                rdy_cnt++;
            end
        end else if (pending) begin
            if (!no_resp && rsp_cnt >= resp_delay) begin
                mem_resp_valid = 1'b1;
                mem_rdata      = p_wen ? {$urandom, $urandom} : memf(p_addr);
                pending        = 0;
                rdy_cnt        = 0;
            end else begin
                rsp_cnt++;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_mem(input int rd, input int dd, input bit nr);
        @(posedge clk);
        #2;
        ready_delay = rd;
        resp_delay  = dd;
        no_resp     = nr;
    endtask

    // one request round: drive, check grant, wait for the routed response, check memory side
    task automatic do_txn(input bit iv, input bit lv, input logic [63:0] ia, input logic [63:0] la,
                          input bit wen, input logic [63:0] wd, input logic [7:0] wm,
                          input int exp_lat, input bit exp_err, input int hold_n, input bit exp_log);
        bit          w;
        logic [63:0] ea;
        logic [63:0] ed;
        int          lat;
        if (iv && lv) w = !ref_last;
        else          w = lv;
        ref_last = w;
        ea = w ? la : ia;
        if (exp_err || (w && wen)) ed = '0;
        else                       ed = memf(ea);
        exp_q.push_back(ed);

        @(negedge clk);
        if_req_valid = iv;
        if_addr      = ia;
        ls_req_valid = lv;
        ls_addr      = la;
        ls_wen       = wen;
        ls_wdata     = wd;
        ls_wmask     = wm;
        #1;
        chk("if_req_ready", if_req_ready, iv && !w);
        chk("ls_req_ready", ls_req_ready, w);

        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) begin
                if_req_valid = 1'b0;
                ls_req_valid = 1'b0;
                chk("owner", owner, w);
                chk("busy", busy, 1'b1);
                chk("mem_addr", mem_addr, ea);
            end
            if (i <= hold_n) begin
                chk("hold_valid", mem_req_valid, 1'b1);
                chk("hold_addr", mem_addr, ea);
            end
            if (if_resp_valid || ls_resp_valid) begin
                lat = i;
                break;
            end
        end
        chk("if_resp_valid", if_resp_valid, !w);
        chk("ls_resp_valid", ls_resp_valid, w);
        chk("rdata", w ? ls_rdata : if_rdata, exp_q.pop_front());
        chk("resp_err", w ? ls_resp_err : if_resp_err, exp_err);
        if (exp_lat > 0) chk("latency", 64'(lat), 64'(exp_lat));
        if (exp_err) chk("withdrawn", mem_req_valid, 1'b0);
        if (exp_log) begin
            chk("log_count", 64'(log_addr.size()), 64'd1);
            if (log_addr.size() > 0) begin
                chk("log_addr", log_addr.pop_front(), ea);
                chk("log_wen", log_wen.pop_front(), w && wen);
                chk("log_wmask", log_wmask.pop_front(), w ? wm : 8'h00);
                if (w && wen) chk("log_wdata", log_wdata.pop_front(), wd);
                else void'(log_wdata.pop_front());
            end
        end
        log_addr.delete();
        log_wen.delete();
        log_wdata.delete();
        log_wmask.delete();

        @(negedge clk);
        chk("back_to_idle", {busy, if_resp_valid, ls_resp_valid}, 3'b000);
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {busy, owner, mem_req_valid, mem_wen, if_resp_valid, ls_resp_valid,
                  if_resp_err, ls_resp_err, if_req_ready, ls_req_ready}, '0);
        chk({tag, "_fields"}, mem_addr | mem_wdata | {56'd0, mem_wmask} | if_rdata | ls_rdata, '0);
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        int          v;
        int          rd;
        int          dd;

        rst          = 1'b0;
        if_req_valid = 1'b0;
        if_addr      = '0;
        ls_req_valid = 1'b0;
        ls_addr      = '0;
        ls_wen       = 1'b0;
        ls_wdata     = '0;
        ls_wmask     = '0;
        ref_last     = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;

        // tie after reset goes to IF, then LS gets the next slot with its write
        do_txn(1, 1, 64'h8000_0000, 64'h1000_0040, 1, 64'hDEAD_BEEF, 8'h0F, 3, 0, 0, 1);
        do_txn(1, 1, 64'h8000_0004, 64'h1000_0040, 1, 64'hDEAD_BEEF, 8'h0F, 3, 0, 0, 1);

        // IF alone, minimum latency
        do_txn(1, 0, 64'h8000_0000, 64'h0, 0, 64'h0, 8'h00, 3, 0, 0, 1);

        // round-robin with continuous ties
        for (int k = 0; k < 6; k++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            do_txn(1, 1, ra, rb, k[0], {$urandom, $urandom}, 8'($urandom), 3, 0, 0, 1);
        end

        // memory backpressure for 5 cycles
        set_mem(5, 0, 0);
        do_txn(0, 1, 64'h0, 64'h2000_0008, 0, 64'h0, 8'h00, 8, 0, 5, 1);

        // watchdog in WAIT, then a stray response while idle
        set_mem(0, 0, 1);
        do_txn(1, 0, 64'h8000_0100, 64'h0, 0, 64'h0, 8'h00, 9, 1, 0, 1);
        @(posedge clk);
        #2;
        late_resp = 1'b1;
        @(posedge clk);
        #2;
        late_resp = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("late_resp_ignored", {busy, if_resp_valid, ls_resp_valid}, 3'b000);
        end

        // response in the watchdog cycle wins; one cycle later it loses
        set_mem(0, 6, 0);
        do_txn(0, 1, 64'h0, 64'h3000_0010, 0, 64'h0, 8'h00, 9, 0, 0, 1);
        set_mem(0, 7, 0);
        do_txn(1, 0, 64'h8000_0200, 64'h0, 0, 64'h0, 8'h00, 9, 1, 0, 1);

        // watchdog while memory never accepts the request
        set_mem(100, 0, 0);
        do_txn(0, 1, 64'h0, 64'h4000_0020, 1, 64'h1234, 8'hFF, 9, 1, 0, 0);

        // randomized traffic
        for (int k = 0; k < 20; k++) begin
            rd = $urandom_range(0, 2);
            dd = $urandom_range(0, 3);
            set_mem(rd, dd, 0);
            v  = $urandom_range(1, 3);
            ra = ($urandom_range(0, 3) == 0) ? 64'h8000_0000 : {$urandom, $urandom};
            rb = {$urandom, $urandom};
            do_txn(v[0], v[1], ra, rb, 1'($urandom), {$urandom, $urandom}, 8'($urandom),
                   3 + rd + dd, 0, 0, 1);
        end

        // reset while waiting on memory abandons the transaction
        set_mem(0, 0, 1);
        @(negedge clk);
        ls_req_valid = 1'b1;
        ls_addr      = 64'h5000_0000;
        ls_wen       = 1'b0;
        @(negedge clk);
        ls_req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_reset_busy", busy, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        rst      = 1'b1;
        ref_last = 1'b1;
        chk_all_zero("mid_reset");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("after_reset_quiet", {busy, if_resp_valid, ls_resp_valid}, 3'b000);
        end
        log_addr.delete();
        log_wen.delete();
        log_wdata.delete();
        log_wmask.delete();
        set_mem(0, 0, 0);
        do_txn(1, 1, 64'h8000_0000, 64'h5000_0008, 0, 64'h0, 8'h00, 3, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
